// File: rtl/ahb_arbiter_if.sv
// AHB arbiter bus bundle: requests, transfer status and grant outputs.
// master modport drives requests; slave modport is the arbiter side.
interface ahb_arbiter_if;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANT;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Four-master AHB round-robin arbiter with burst tracking.
// Define AHB_ARBITER_HLOCK_EN to support locked transfers.
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0
) (
  input logic            HCLK,
  input logic            HRESET,
  ahb_arbiter_if.slave   bus
);

  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  localparam logic [3:0] DEF_OH = 4'b0001 << DEF;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;
  localparam logic [1:0] ERROR = 2'b01;

  logic [3:0] grant_q, grant_d;
  logic [3:0] master_q, master_d;
  logic       mastlock_q, mastlock_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic       lock_dly_q, lock_dly_d;

  logic [1:0] gidx;
  logic [1:0] win;
  logic       any_req;
  logic [3:0] len;
  logic       lock_cur;
  logic       hold;
  logic       lock_bit;
  logic       allow;

  // Encode the one-hot grant into the owner index.
  always_comb begin
    gidx = 2'd0;
    unique case (1'b1)
      grant_q[0]: gidx = 2'd0;
      grant_q[1]: gidx = 2'd1;
      grant_q[2]: gidx = 2'd2;
      grant_q[3]: gidx = 2'd3;
      default:    gidx = 2'd0;
    endcase
  end

  // Round-robin search starting after the last requesting winner.
  always_comb begin
    logic [1:0] idx;
    win = DEF;
    any_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!any_req && bus.HBUSREQ[idx]) begin
        win = idx;
        any_req = 1'b1;
      end
    end
  end

  // Remaining SEQ beats implied by the burst type.
  always_comb begin
    len = 4'd0;
    case (bus.HBURST[2:1])
      2'b00:   len = 4'd0;
      2'b01:   len = 4'd3;
      2'b10:   len = 4'd7;
      default: len = 4'd15;
    endcase
  end

  // Lock hold: owner locked now, or was locked in the previous cycle.
`ifdef AHB_ARBITER_HLOCK_EN
  always_comb begin
    lock_bit = bus.HLOCK[gidx];
    lock_cur = bus.HLOCK[gidx] & bus.HBUSREQ[gidx];
    hold = lock_cur | lock_dly_q;
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.HLOCK;
  always_comb begin
    lock_bit = 1'b0;
    lock_cur = 1'b0;
    hold = 1'b0;
  end
`endif

  logic unused_burst;
  assign unused_burst = bus.HBURST[0];

  // Next-state for beat counter, grant and address-phase owner.
  always_comb begin
    if (bus.HRESP == ERROR)
      cnt_d = 4'd0;
    else if (bus.HREADY && bus.HTRANS == NONSEQ)
      cnt_d = len;
    else if (bus.HREADY && bus.HTRANS == SEQ && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
    else
      cnt_d = cnt_q;

    allow = bus.HREADY && (cnt_d == 4'd0) && !hold;

    grant_d = grant_q;
    last_d = last_q;
    if (allow) begin
      grant_d = 4'b0001 << win;
      if (any_req && win != gidx)
        last_d = win;
    end

    master_d = bus.HREADY ? {2'b00, gidx} : master_q;
    mastlock_d = bus.HREADY ? lock_bit : mastlock_q;
    lock_dly_d = lock_cur;
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q    <= DEF_OH;
      master_q   <= {2'b00, DEF};
      mastlock_q <= 1'b0;
      cnt_q      <= 4'd0;
      last_q     <= DEF;
      lock_dly_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      lock_dly_q <= lock_dly_d;
    end
  end

  assign bus.HGRANT = grant_q;
  assign bus.HMASTER = master_q;
  assign bus.HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: vector table plus
// hand sequences for error abort, lock and mid-burst reset.
module tb_ahb_arbiter;

  logic HCLK;
  logic HRESET;
  ahb_arbiter_if bus ();

  ahb_arbiter #(.DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000;
  localparam logic [2:0] I4 = 3'b011;
  localparam logic [2:0] I8 = 3'b101;
  localparam logic [2:0] I16 = 3'b111;

  typedef struct {
    string      nm;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic [1:0] rsp;
    logic [3:0] g;
    logic [3:0] m;
    logic       ml;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    string nm, logic rst, logic [3:0] req, logic [3:0] lck,
    logic [1:0] tr, logic [2:0] bu, logic rdy, logic [1:0] rsp,
    logic [3:0] g, logic [3:0] m, logic ml);
    vec_t v;
    v.nm = nm; v.rst = rst; v.req = req; v.lck = lck;
    v.tr = tr; v.bu = bu; v.rdy = rdy; v.rsp = rsp;
    v.g = g; v.m = m; v.ml = ml;
    return v;
  endfunction

  task automatic cmp(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] req, logic [3:0] lck,
                       logic [1:0] tr, logic [2:0] bu, logic rdy,
                       logic [1:0] rsp);
    HRESET = rst;
    bus.HBUSREQ = req;
    bus.HLOCK = lck;
    bus.HTRANS = tr;
    bus.HBURST = bu;
    bus.HREADY = rdy;
    bus.HRESP = rsp;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(string nm, logic [3:0] g, logic [3:0] m, logic ml);
    cmp({nm, ".grant"}, bus.HGRANT, g);
    cmp({nm, ".master"}, bus.HMASTER, m);
    cmp({nm, ".mastlock"}, {3'b000, bus.HMASTLOCK}, {3'b000, ml});
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 4'b0000, IDL, SGL, 1'b1, 2'b00);
  endtask

  initial begin
    HRESET = 1'b1;
    bus.HBUSREQ = '0;
    bus.HLOCK = '0;
    bus.HTRANS = IDL;
    bus.HBURST = SGL;
    bus.HREADY = 1'b1;
    bus.HRESP = 2'b00;

    // reset, with noisy inputs on the second vector
    tbl.push_back(mk("rst0", 1, 4'h0, 4'h0, IDL, SGL, 1, 0, 4'b0001, 0, 0));
    tbl.push_back(mk("rst1", 1, 4'hF, 4'hF, NSQ, I16, 1, 0, 4'b0001, 0, 0));
    // idle bus holds default master
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("idle", 0, 4'h0, 4'h0, IDL, SGL, 1, 0, 4'b0001, 0, 0));
    // round robin with all masters requesting
    tbl.push_back(mk("rr1", 0, 4'hF, 4'h0, NSQ, SGL, 1, 0, 4'b0010, 0, 0));
    tbl.push_back(mk("rr2", 0, 4'hF, 4'h0, NSQ, SGL, 1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk("rr3", 0, 4'hF, 4'h0, NSQ, SGL, 1, 0, 4'b1000, 2, 0));
    tbl.push_back(mk("rr4", 0, 4'hF, 4'h0, NSQ, SGL, 1, 0, 4'b0001, 3, 0));
    tbl.push_back(mk("rr5", 0, 4'hF, 4'h0, NSQ, SGL, 1, 0, 4'b0010, 0, 0));
    // master 1 INCR4 with a wait state; master 2 waiting
    tbl.push_back(mk("b_ns", 0, 4'h6, 4'h0, NSQ, I4, 1, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("b_s1", 0, 4'h6, 4'h0, SQ, I4, 1, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("b_wt", 0, 4'h4, 4'h0, SQ, I4, 0, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("b_s2", 0, 4'h6, 4'h0, SQ, I4, 1, 0, 4'b0010, 1, 0));
    tbl.push_back(mk("b_s3", 0, 4'h6, 4'h0, SQ, I4, 1, 0, 4'b0100, 1, 0));
    tbl.push_back(mk("b_hw", 0, 4'h4, 4'h0, IDL, SGL, 0, 0, 4'b0100, 1, 0));
    tbl.push_back(mk("b_hm", 0, 4'h4, 4'h0, NSQ, SGL, 1, 0, 4'b0100, 2, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].req, tbl[k].lck, tbl[k].tr,
            tbl[k].bu, tbl[k].rdy, tbl[k].rsp);
      chk(tbl[k].nm, tbl[k].g, tbl[k].m, tbl[k].ml);
    end

    // ERROR abort of master 0 INCR8, master 3 waiting
    do_reset();
    drive(0, 4'b1001, 0, NSQ, I8, 1, 2'b00);
    chk("e_ns", 4'b0001, 0, 0);
    drive(0, 4'b1001, 0, SQ, I8, 1, 2'b00);
    chk("e_s1", 4'b0001, 0, 0);
    cmp("e_cnt6", dut.cnt_q, 4'd6);
    drive(0, 4'b1001, 0, SQ, I8, 0, 2'b01);
    chk("e_err1", 4'b0001, 0, 0);
    cmp("e_cnt0", dut.cnt_q, 4'd0);
    drive(0, 4'b1001, 0, IDL, SGL, 1, 2'b01);
    chk("e_err2", 4'b1000, 0, 0);
    drive(0, 4'b1000, 0, IDL, SGL, 1, 2'b00);
    chk("e_own", 4'b1000, 3, 0);

    // locked run by master 2, masters 0 and 1 requesting
    do_reset();
    drive(0, 4'b0100, 4'b0100, NSQ, SGL, 1, 0);
    chk("l_gnt", 4'b0100, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 4'b0111, 4'b0100, NSQ, SGL, 1, 0);
`ifdef AHB_ARBITER_HLOCK_EN
      chk($sformatf("l_run%0d", i), 4'b0100, 2, 1);
`else
      case (i % 3)
        0: chk($sformatf("l_rot%0d", i), 4'b0001, 2, 0);
        1: chk($sformatf("l_rot%0d", i), 4'b0010, 0, 0);
        default: chk($sformatf("l_rot%0d", i), 4'b0100, 1, 0);
      endcase
`endif
    end
    drive(0, 4'b0111, 4'b0000, NSQ, SGL, 1, 0);
`ifdef AHB_ARBITER_HLOCK_EN
    chk("l_tail", 4'b0100, 2, 0);
`else
    chk("l_tail", 4'b0001, 2, 0);
`endif
    drive(0, 4'b0111, 4'b0000, NSQ, SGL, 1, 0);
`ifdef AHB_ARBITER_HLOCK_EN
    chk("l_rel", 4'b0001, 2, 0);
`else
    chk("l_rel", 4'b0010, 0, 0);
`endif

    // reset during beat 3 of an INCR16 by master 3
    do_reset();
    drive(0, 4'b1000, 4'b1000, IDL, SGL, 1, 0);
    chk("r_gnt", 4'b1000, 0, 0);
    drive(0, 4'b1000, 4'b1000, NSQ, I16, 1, 0);
    drive(0, 4'b1000, 4'b1000, SQ, I16, 1, 0);
    cmp("r_cnt14", dut.cnt_q, 4'd14);
    drive(1, 4'b1000, 4'b1000, SQ, I16, 1, 0);
    chk("r_rst", 4'b0001, 0, 0);
    cmp("r_cnt0", dut.cnt_q, 4'd0);
    drive(0, 4'b0010, 4'b0000, IDL, SGL, 1, 0);
    chk("r_first", 4'b0010, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter DEFAULT_MASTER, 0, index (0..3) of the master granted when no master requests the bus.
REQ-002 HCLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 HRESET  input  1  reset, synchronous and active-high.
REQ-004 HBUSREQ  input  4  bus request, bit x from master x.
REQ-005 HLOCK  input  4  locked-transfer request, bit x from master x.
REQ-006 HTRANS  input  2  current address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 HBURST  input  3  current burst type (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16).
REQ-008 HREADY  input  1  muxed slave ready.
REQ-009 HRESP  input  2  muxed slave response (01 ERROR).
REQ-010 HGRANT  output  4  registered one-hot grant.
REQ-011 HMASTER  output  4  registered index of the master owning the address phase (upper 2 bits always 0).
REQ-012 HMASTLOCK  output  1  registered: current address-phase transfer is locked.

Function
REQ-013 HGRANT SHALL be exactly one-hot in every cycle after reset.
REQ-014 Beat counter cnt (4 bits) SHALL hold the remaining SEQ beats of the current fixed-length burst.
- cnt_next: HREADY & NONSEQ loads len-1 (3/7/15 for 4/8/16-beat; 0 for SINGLE/INCR).
- HREADY & SEQ & cnt!=0 decrements.
- HRESP==ERROR clears to 0.
- Otherwise holds.
REQ-015 BUSY and IDLE SHALL NOT change cnt.
REQ-016 Rearbitration SHALL be allowed in a cycle only when HREADY=1, cnt_next==0 and the lock hold (REQ-021) is inactive.
- INCR bursts are therefore rearbitrable at every accepted beat.
REQ-017 On an allowed cycle, HGRANT SHALL load the winner at the next edge.
- Winner is the first requesting master in round-robin order starting at (last_granted+1) mod 4.
- If no HBUSREQ bit is set, the winner is DEFAULT_MASTER.
REQ-018 last_granted SHALL update only when HGRANT changes to a requesting master; a default grant SHALL NOT move it.
REQ-019 When rearbitration is not allowed, HGRANT SHALL hold, even if the owner drops HBUSREQ.
REQ-020 HMASTER SHALL load the index of the current HGRANT on every edge where HREADY=1, and hold otherwise.
- Handover: old master's last address accepted in cycle T; HGRANT changes at T+1; HMASTER changes at the end of the first HREADY=1 cycle from T+1 onward.
REQ-021 Lock hold (macro-dependent, see REQ-029/030).
- Active while granted master g has HLOCK[g]=1 and HBUSREQ[g]=1.
- It is also active for the single cycle after g deasserts HLOCK, so the last locked beat completes before handover.
REQ-022 HMASTLOCK SHALL load HLOCK[granted index] on edges where HREADY=1, and hold otherwise.
REQ-023 Simultaneous NONSEQ of a new burst and the final beat: the NONSEQ load SHALL take precedence.
REQ-024 HRESP ERROR while HREADY=0 SHALL still clear cnt.

Reset
REQ-025 While HRESET=1 at an edge, the following SHALL be forced regardless of other inputs:
- HGRANT = one-hot(DEFAULT_MASTER).
- HMASTER = DEFAULT_MASTER.
- HMASTLOCK = 0.
- cnt = 0.
- last_granted = DEFAULT_MASTER.
- Lock hold cleared.
REQ-026 Reset asserted mid-burst or mid-lock SHALL abandon the burst; no state SHALL survive reset.
REQ-027 The first rearbitration after reset deassertion SHALL occur in the first HREADY=1 cycle.

Configuration
REQ-028 Macro AHB_ARBITER_HLOCK_EN SHALL select whether locked transfers are supported.
REQ-029 With AHB_ARBITER_HLOCK_EN defined:
- Lock hold and HMASTLOCK SHALL behave per REQ-021/022.
REQ-030 Without AHB_ARBITER_HLOCK_EN:
- HLOCK SHALL be ignored.
- Lock hold SHALL be permanently inactive.
- HMASTLOCK SHALL be constant 0.
- Port list SHALL be unchanged.

Verification
REQ-031 Idle bus: HBUSREQ=0000, HREADY=1 for 5 cycles after reset -> HGRANT=0001, HMASTER=0 throughout.
REQ-032 Round-robin: HBUSREQ=1111, HTRANS NONSEQ SINGLE, HREADY=1 every cycle -> HGRANT sequence 0010, 0100, 1000, 0001, 0010.
REQ-033 Burst hold: master 1 granted issues NONSEQ INCR4 then 3 SEQ, one HREADY=0 cycle mid-burst, master 2 requesting:
- HGRANT stays 0010 until the cycle after the third SEQ is accepted, then becomes 0100.
- HMASTER becomes 2 on the next HREADY=1 edge.
REQ-034 ERROR abort: HRESP=01 during the second beat of an INCR8 by master 0, master 3 requesting -> cnt=0 and HGRANT=1000 on the next HREADY=1 cycle.
REQ-035 Lock (macro on): master 2 asserts HLOCK+HBUSREQ for 6 SINGLE NONSEQ transfers, masters 0 and 1 requesting:
- HGRANT stays 0100 and HMASTLOCK=1 for all 6.
- HGRANT changes to 1000-order winner 0001 one cycle after HLOCK[2] drops.
- With the macro off, HMASTLOCK stays 0 and the grant rotates every transfer.
REQ-036 Mid-burst reset: HRESET=1 during beat 3 of an INCR16 by master 3 -> next cycle HGRANT=0001, HMASTER=0, HMASTLOCK=0, cnt=0.
